// File: rtl/controller_sequencer.sv
// Six-phase control sequencer for the 8-bit accumulator CPU: a one-hot T-state
// ring plus opcode decode produces the per-cycle control word and latches halt.
module controller_sequencer #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm_bar,
  output logic       ce_bar,
  output logic       li_bar,
  output logic       ei_bar,
  output logic       la_bar,
  output logic       ea,
  output logic       su,
  output logic       eu,
  output logic       lb_bar,
  output logic       lo_bar,
  output logic [5:0] t_state,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  t_state_e state_q, state_d;
  logic     halted_q, halted_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Once halted the ring parks on T5, the state it reached leaving the HLT T4.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        T1:      state_d = T2;
        T2:      state_d = T3;
        T3:      state_d = T4;
        T4:      state_d = T5;
        T5:      state_d = T6;
        T6:      state_d = T1;
        default: state_d = T1;
      endcase
      if (state_q == T4 && opcode == OP_HLT) halted_d = 1'b1;
    end
  end

  // Opcode is decoded unregistered; the IR holds it steady through T4-T6.
  always_comb begin
    cp     = 1'b0;
    ep     = 1'b0;
    ea     = 1'b0;
    su     = 1'b0;
    eu     = 1'b0;
    lm_bar = 1'b1;
    ce_bar = 1'b1;
    li_bar = 1'b1;
    ei_bar = 1'b1;
    la_bar = 1'b1;
    lb_bar = 1'b1;
    lo_bar = 1'b1;
    if (!rst && !halted_q) begin
      case (state_q)
        T1: begin
          ep     = 1'b1;
          lm_bar = 1'b0;
        end
        T2: cp = 1'b1;
        T3: begin
          ce_bar = 1'b0;
          li_bar = 1'b0;
        end
        T4: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ei_bar = 1'b0;
            lm_bar = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea     = 1'b1;
            lo_bar = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce_bar = 1'b0;
            la_bar = 1'b0;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ce_bar = 1'b0;
            lb_bar = 1'b0;
          end
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu     = 1'b1;
            la_bar = 1'b0;
            su     = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign t_state = state_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_controller_sequencer.sv
// Bench for controller_sequencer: random opcode/reset stimulus checked every
// cycle against a phase-counter model of the instruction table.
module tb_controller_sequencer;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] opcode;
  logic       cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar;
  logic [5:0] t_state;
  logic       halted;

  int vectors = 0;
  int miscompares = 0;
  int m_phase = 0;
  logic m_halted = 1'b0;

  always #5 clk = ~clk;

  controller_sequencer dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .cp(cp), .ep(ep), .lm_bar(lm_bar), .ce_bar(ce_bar), .li_bar(li_bar),
    .ei_bar(ei_bar), .la_bar(la_bar), .ea(ea), .su(su), .eu(eu),
    .lb_bar(lb_bar), .lo_bar(lo_bar), .t_state(t_state), .halted(halted)
  );

  // Word order: cp ep lm ce li ei la ea su eu lb lo
  function automatic logic [11:0] model_word(int ph, logic [3:0] op, logic h, logic r);
    logic w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo;
    w_cp = 0; w_ep = 0; w_ea = 0; w_su = 0; w_eu = 0;
    w_lm = 1; w_ce = 1; w_li = 1; w_ei = 1; w_la = 1; w_lb = 1; w_lo = 1;
    if (!r && !h) begin
      if (ph == 0) begin w_ep = 1; w_lm = 0; end
      if (ph == 1) w_cp = 1;
      if (ph == 2) begin w_ce = 0; w_li = 0; end
      if (ph == 3 && (op == OP_LDA || op == OP_ADD || op == OP_SUB)) begin w_ei = 0; w_lm = 0; end
      if (ph == 3 && op == OP_OUT) begin w_ea = 1; w_lo = 0; end
      if (ph == 4 && op == OP_LDA) begin w_ce = 0; w_la = 0; end
      if (ph == 4 && (op == OP_ADD || op == OP_SUB)) begin w_ce = 0; w_lb = 0; end
      if (ph == 5 && op == OP_ADD) begin w_eu = 1; w_la = 0; end
      if (ph == 5 && op == OP_SUB) begin w_eu = 1; w_la = 0; w_su = 1; end
    end
    return {w_cp, w_ep, w_lm, w_ce, w_li, w_ei, w_la, w_ea, w_su, w_eu, w_lb, w_lo};
  endfunction

  // Apply inputs for one cycle, check outputs mid-cycle, then clock the model.
  task automatic cycle(input logic r, input logic [3:0] op);
    logic [11:0] exp_w, act_w;
    logic [5:0]  exp_t;
    int drivers;
    rst = r;
    opcode = op;
    #1;
    exp_t = 6'b000001 << m_phase;
    exp_w = model_word(m_phase, op, m_halted, r);
    act_w = {cp, ep, lm_bar, ce_bar, li_bar, ei_bar, la_bar, ea, su, eu, lb_bar, lo_bar};
    drivers = int'(ep) + int'(!ce_bar) + int'(!ei_bar) + int'(ea) + int'(eu);
    vectors++;
    if (t_state !== exp_t) begin
      miscompares++;
      $display("FAIL t_state: got %b expected %b (op=%h rst=%b)", t_state, exp_t, op, r);
    end
    vectors++;
    if (halted !== m_halted) begin
      miscompares++;
      $display("FAIL halted: got %b expected %b", halted, m_halted);
    end
    vectors++;
    if (act_w !== exp_w) begin
      miscompares++;
      $display("FAIL control_word: got %b expected %b (phase T%0d op=%h rst=%b)",
               act_w, exp_w, m_phase + 1, op, r);
    end
    vectors++;
    if (drivers > 1) begin
      miscompares++;
      $display("FAIL bus_drivers: got %0d active expected at most 1", drivers);
    end
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_halted = 1'b0;
    end else if (!m_halted) begin
      if (m_phase == 3 && op == OP_HLT) m_halted = 1'b1;
      m_phase = (m_phase + 1) % 6;
    end
    #1;
  endtask

  function automatic logic [3:0] rand_non_halt();
    logic [3:0] v;
    v = 4'($urandom_range(0, 14));
    return v;
  endfunction

  // Advance with harmless random opcodes until the model reaches phase p.
  task automatic run_to_phase(input int p);
    if (m_halted) cycle(1'b1, rand_non_halt());
    for (int i = 0; i < 8 && m_phase != p; i++) cycle(1'b0, rand_non_halt());
    if (m_phase != p) begin
      vectors++;
      miscompares++;
      $display("FAIL run_to_phase: got T%0d expected T%0d", m_phase + 1, p + 1);
    end
  endtask

  task automatic run_instr(input logic [3:0] op);
    run_to_phase(0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'($urandom_range(0, 15)));
    for (int i = 0; i < 3; i++) cycle(1'b0, op);
  endtask

  task automatic test_reset();
    cycle(1'b1, 4'($urandom_range(0, 15)));
    cycle(1'b1, OP_ADD);
    cycle(1'b0, OP_LDA);
  endtask

  task automatic test_lda();
    for (int i = 0; i < 13; i++) cycle(1'b0, OP_LDA);
  endtask

  task automatic test_add_sub();
    run_instr(OP_ADD);
    run_instr(OP_SUB);
  endtask

  task automatic test_out();
    run_instr(OP_OUT);
  endtask

  task automatic test_undefined();
    run_instr(4'b0111);
    run_instr(OP_LDA);
  endtask

  task automatic test_hlt();
    run_to_phase(3);
    cycle(1'b0, OP_HLT);
    for (int i = 0; i < 24; i++) cycle(1'b0, (i < 12) ? OP_HLT : OP_LDA);
    cycle(1'b1, OP_LDA);
    for (int i = 0; i < 6; i++) cycle(1'b0, OP_LDA);
  endtask

  task automatic test_reset_mid();
    run_to_phase(0);
    for (int i = 0; i < 4; i++) cycle(1'b0, OP_ADD);
    cycle(1'b1, OP_ADD);
    for (int i = 0; i < 6; i++) cycle(1'b0, OP_ADD);
  endtask

  task automatic test_rst_hlt_same_cycle();
    run_to_phase(3);
    cycle(1'b1, OP_HLT);
    for (int i = 0; i < 4; i++) cycle(1'b0, OP_LDA);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 29) == 0) || (m_halted && $urandom_range(0, 7) == 0),
            4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    rst = 1'b1;
    opcode = OP_LDA;
    @(posedge clk);
    m_phase = 0;
    m_halted = 1'b0;
    #1;
    test_reset();
    test_lda();
    test_add_sub();
    test_out();
    test_undefined();
    test_hlt();
    test_reset_mid();
    test_rst_hlt_same_cycle();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
